uart_tensor_loader: RTL and testbench
=====================================

UART_TENSOR_LOADER -- requirements
Module: uart_tensor_loader

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated.
REQ-003 Parameter NUMBER_OF_INPUTS, default 4, number of input tensors held in the destination memory.
REQ-004 Parameter IN_CHANNELS, default 1, channels per tensor.
REQ-005 Parameter IN_SIZE, default 8, tensor height and width.
REQ-006 Parameter DATA_SIZE, default 8, element width; SHALL equal 8 (one byte per element), checked at elaboration.
REQ-007 Parameter TIMEOUT_CYCLES, default 10*CLKS_PER_BIT*4, maximum idle gap between bytes inside a frame.
REQ-008 Derived constants: ELEMS = IN_CHANNELS*IN_SIZE*IN_SIZE; AW = clog2(NUMBER_OF_INPUTS*ELEMS).
REQ-009 clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 rx  in  1  asynchronous UART line: 8N1, LSB first, idle high.
REQ-012 wr_en  out  1  one-cycle write strobe to the tensor memory.
REQ-013 wr_addr  out  AW  flat address: index*ELEMS + ((c*IN_SIZE + row)*IN_SIZE + col).
REQ-014 wr_data  out  DATA_SIZE  element value.
REQ-015 load_done  out  1  one-cycle pulse when a frame completes with a good checksum.
REQ-016 done_index  out  clog2(NUMBER_OF_INPUTS)  index of the last good frame; holds until the next load_done.
REQ-017 err  out  1  one-cycle pulse when a frame is aborted.
REQ-018 err_code  out  2  reason for the abort: 1 = bad index, 2 = checksum mismatch, 3 = line error (stop bit or timeout); holds until the next err.
REQ-019 busy  out  1  high in every frame state except IDLE.

Function
REQ-020 Input path SHALL be a two-flop synchronizer on rx; the flops reset high.
REQ-021 Byte receiver behaviour:
- A falling edge starts a byte; the start bit is revalidated low at CLKS_PER_BIT/2, otherwise the receiver returns to idle silently.
- Data bits are sampled at the centre of each bit period.
- Stop bit is sampled at its centre; if it is 0, the byte is discarded and a line error is raised.
- A byte_valid pulse is raised for one cycle per good byte.
REQ-022 Frame format: 0xA5 header, index byte, ELEMS payload bytes in flat order, then a checksum byte equal to the XOR of all payload bytes.
REQ-023 FSM states and transitions:
- IDLE: a 0xA5 byte moves to INDEX; any other byte is ignored.
- INDEX: an index < NUMBER_OF_INPUTS latches and moves to PAYLOAD; otherwise err with code 1 and return to IDLE.
- PAYLOAD: each byte asserts wr_en for one cycle and updates the running XOR; after ELEMS bytes, move to CHECK.
- CHECK: a match pulses load_done; a mismatch gives err with code 2; either way, return to IDLE.
REQ-024 wr_en, wr_addr and wr_data SHALL be registered, asserted the cycle after byte_valid, and stable during that cycle.
REQ-025 The element counter SHALL count 0..ELEMS-1 and clear on entry to PAYLOAD; wr_addr SHALL never exceed index*ELEMS+ELEMS-1.
REQ-026 Payload writes SHALL be committed even if the checksum later fails; load_done/err only qualify the frame.
REQ-027 Timeout: in INDEX, PAYLOAD or CHECK, TIMEOUT_CYCLES without a byte_valid SHALL raise err with code 3 and return to IDLE.
REQ-028 A line error in any non-IDLE state SHALL raise err with code 3 and return to IDLE; in IDLE it is ignored.
REQ-029 load_done and err SHALL never be asserted in the same cycle.
REQ-030 A 0xA5 byte inside PAYLOAD is data, not a resync.

Reset
REQ-031 On reset, outputs SHALL be: wr_en=0, wr_addr=0, wr_data=0, load_done=0, done_index=0, err=0, err_code=0, busy=0.
REQ-032 On reset, internal state SHALL be: FSM=IDLE, byte receiver idle, running XOR=0, counters=0, timeout counter=0.
REQ-033 Reset mid-frame SHALL abandon the frame without any err pulse; memory already written is left as is.

Structure
REQ-034 The frame header constant (0xA5), err_code encodings and the FSM state enum SHALL live in the shared package loader_pkg.
REQ-035 Byte reception SHALL be a sub-module uart_rx (clk, reset, rx_sync, byte_valid, byte_data, line_err) instantiated once.
REQ-036 The block SHALL contain no memory; it drives a write port that the top level connects to its inputs array.

Verification (NUMBER_OF_INPUTS=2, IN_CHANNELS=1, IN_SIZE=2, ELEMS=4)
REQ-037 Send A5 01 10 20 30 40 40 -> four writes (addr 4..7, data 10/20/30/40), then load_done with done_index=1, and no err.
REQ-038 Send A5 02 ... -> err with code 1, no wr_en, FSM back in IDLE; a following good frame to index 0 writes addr 0..3.
REQ-039 Send A5 00 01 02 03 04 FF -> four writes, then err with code 2 and no load_done.
REQ-040 Send A5 00 11 22, then silence for TIMEOUT_CYCLES+1 -> err with code 3 and busy falls; a stop bit forced to 0 mid-frame also gives code 3.
REQ-041 Assert reset after A5 01 33 -> all outputs at reset values, no err; a fresh full frame then completes normally.
REQ-042 Send 00 A5 A5 A5 ... -> the leading 00 is ignored, the second A5 is taken as the index (0xA5 ≥ 2, so err code 1), and the payload A5 is written as data in a valid frame.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART tensor loader.
package loader_pkg;

    // First byte of every frame.
    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Abort reasons reported on err_code.
    localparam logic [1:0] ERR_BAD_INDEX = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM  = 2'd2;
    localparam logic [1:0] ERR_LINE      = 2'd3;

    // Frame parser states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INDEX   = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHECK   = 2'd3
    } frame_state_e;

    // Byte receiver states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_tensor_loader_if.sv
// Write port and frame status of the loader, as seen by the tensor memory.
interface uart_tensor_loader_if #(
    parameter int AW = 3,
    parameter int IW = 1,
    parameter int DW = 8
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          load_done;
    logic [IW-1:0] done_index;
    logic          err;
    logic [1:0]    err_code;
    logic          busy;

    modport master (
        output wr_en, wr_addr, wr_data, load_done, done_index, err, err_code, busy
    );

    modport slave (
        input wr_en, wr_addr, wr_data, load_done, done_index, err, err_code, busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 byte receiver: start-bit revalidation, centre sampling, stop-bit check.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       line_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        prev_q;
    logic        valid_q, valid_d;
    logic        lerr_q, lerr_d;

    // Next-state logic: every counter wraps at a sampling point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        lerr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A glitch that is gone by mid-bit is dropped silently.
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    state_d = RX_IDLE;
                    valid_d = rx_sync;
                    lerr_d  = !rx_sync;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state registers; the previous-sample flop idles high like the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= rx_sync;
            valid_q <= valid_d;
            lerr_q  <= lerr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign line_err   = lerr_q;
endmodule

// File: rtl/uart_tensor_loader.sv
// Receives framed tensors over UART and streams their elements to a write port.
module uart_tensor_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ         = 100000000,
    parameter int BAUD             = 115200,
    parameter int NUMBER_OF_INPUTS = 4,
    parameter int IN_CHANNELS      = 1,
    parameter int IN_SIZE          = 8,
    parameter int DATA_SIZE        = 8,
    parameter int TIMEOUT_CYCLES   = 10 * (CLK_FREQ / BAUD) * 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    uart_tensor_loader_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int ELEMS = IN_CHANNELS * IN_SIZE * IN_SIZE;
    localparam int AW = $clog2(NUMBER_OF_INPUTS * ELEMS);
    localparam int IW = (NUMBER_OF_INPUTS > 1) ? $clog2(NUMBER_OF_INPUTS) : 1;
    localparam int EW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Each element occupies exactly one byte of the frame.
    if (DATA_SIZE != 8) begin : g_bad_data_size
        $error("uart_tensor_loader: DATA_SIZE must be 8");
    end

    logic rx_meta_q, rx_sync_q;
    logic       byte_valid, line_err;
    logic [7:0] byte_data;

    frame_state_e   state_q, state_d;
    logic [IW-1:0]  index_q, index_d;
    logic [EW-1:0]  elem_q, elem_d;
    logic [7:0]     xor_q, xor_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           wr_en_q, wr_en_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           load_done_q, load_done_d;
    logic [IW-1:0]  done_index_q, done_index_d;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;

    // Two-flop synchronizer on the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_sync    (rx_sync_q),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .line_err   (line_err)
    );

    // Frame parser; line errors and timeouts override any state once a frame has started.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        elem_d       = elem_q;
        xor_d        = xor_q;
        tmo_d        = (state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_done_d  = 1'b0;
        done_index_d = done_index_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        case (state_q)
            ST_IDLE: begin
                if (byte_valid && byte_data == FRAME_HEADER) state_d = ST_INDEX;
            end
            ST_INDEX: begin
                if (byte_valid) begin
                    if (32'(byte_data) < NUMBER_OF_INPUTS) begin
                        index_d = byte_data[IW-1:0];
                        elem_d  = '0;
                        xor_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_BAD_INDEX;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid) begin
                    // A header value here is ordinary data.
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(index_q) * AW'(ELEMS) + AW'(elem_q);
                    wr_data_d = byte_data;
                    xor_d     = xor_q ^ byte_data;
                    if (elem_q == EW'(ELEMS - 1)) state_d = ST_CHECK;
                    else                          elem_d  = elem_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (byte_valid) begin
                    if (byte_data == xor_q) begin
                        load_done_d  = 1'b1;
                        done_index_d = index_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CHECKSUM;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
            if (byte_valid) begin
                tmo_d = '0;
            end else if (line_err || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                err_d      = 1'b1;
                err_code_d = ERR_LINE;
                state_d    = ST_IDLE;
            end
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            elem_q       <= '0;
            xor_q        <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            done_index_q <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            elem_q       <= elem_d;
            xor_q        <= xor_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
            done_index_q <= done_index_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.load_done  = load_done_q;
    assign bus.done_index = done_index_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_tensor_loader.sv
// Self-checking bench: drives UART byte streams and compares the observed
// writes and frame results against a frame-parsing reference model.
module tb_uart_tensor_loader;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int NI       = 2;
    localparam int IC       = 1;
    localparam int IS       = 2;
    localparam int ELEMS    = IC * IS * IS;
    localparam int AW       = $clog2(NI * ELEMS);
    localparam int IW       = 1;
    localparam int TMO      = 10 * CPB * 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;

    always #5 clk = ~clk;

    uart_tensor_loader_if #(.AW(AW), .IW(IW), .DW(8)) bus ();

    uart_tensor_loader #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUMBER_OF_INPUTS(NI),
        .IN_CHANNELS(IC), .IN_SIZE(IS), .DATA_SIZE(8), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int obs_q[$];
    int exp_q[$];

    function automatic int ev_wr(input int addr, input logic [7:0] data);
        return 32'h10000 | (addr << 8) | int'(data);
    endfunction
    function automatic int ev_done(input int idx);
        return 32'h20000 | idx;
    endfunction
    function automatic int ev_err(input int code);
        return 32'h30000 | code;
    endfunction

    // Record every write strobe and frame result away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.wr_en) obs_q.push_back(ev_wr(int'(bus.wr_addr), bus.wr_data));
            if (bus.load_done) obs_q.push_back(ev_done(int'(bus.done_index)));
            if (bus.err) obs_q.push_back(ev_err(int'(bus.err_code)));
            if (bus.load_done || bus.err) begin
                n_checks++;
                if (bus.load_done && bus.err) begin
                    n_fail++;
                    $display("FAIL done_err_exclusive: both load_done and err high at %0t", $time);
                end
            end
        end
    end

    // Reference: parse a byte stream by frame rules. With abort set, a frame
    // left unfinished at the end of the stream is expected to end in a line error.
    function automatic void model(input logic [7:0] s[$], input bit abort);
        int i = 0;
        int n = s.size();
        int idx;
        int k;
        logic [7:0] x;
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) begin
                if (abort) exp_q.push_back(ev_err(3));
                break;
            end
            idx = int'(s[i]);
            i++;
            if (idx >= NI) begin
                exp_q.push_back(ev_err(1));
                continue;
            end
            x = 8'h00;
            k = 0;
            while (k < ELEMS && i < n) begin
                exp_q.push_back(ev_wr(idx * ELEMS + k, s[i]));
                x = x ^ s[i];
                k++;
                i++;
            end
            if (i >= n) begin
                if (abort) exp_q.push_back(ev_err(3));
                break;
            end
            if (s[i] == x) exp_q.push_back(ev_done(idx));
            else           exp_q.push_back(ev_err(2));
            i++;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic check_events(input string name);
        int n;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d events, expected %0d", name, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_event%0d: got %h, expected %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic check_outputs_reset(input string name);
        @(negedge clk);
        n_checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.load_done, bus.done_index,
             bus.err, bus.err_code, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL %s: wr_en=%b addr=%h data=%h done=%b idx=%h err=%b code=%h busy=%b, expected all 0",
                     name, bus.wr_en, bus.wr_addr, bus.wr_data, bus.load_done, bus.done_index,
                     bus.err, bus.err_code, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        check_outputs_reset("reset_outputs");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        check_outputs_reset("after_reset_outputs");
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        logic [7:0] s[$] = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        check_bit("good_busy_mid", bus.busy, 1'b1);
        for (int i = 2; i < s.size(); i++) send_byte(s[i], 1'b1);
        model(s, 1'b0);
        check_events("good_frame");
        check_bit("good_busy_end", bus.busy, 1'b0);
        n_checks++;
        if (bus.done_index !== 1'b1) begin
            n_fail++;
            $display("FAIL good_done_index_hold: got %0d, expected 1", bus.done_index);
        end
        $display("test_good_frame done");
    endtask

    task automatic test_bad_index();
        logic [7:0] s[$] = '{8'hA5, 8'h02, 8'hA5, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0C};
        send_stream(s);
        model(s, 1'b0);
        check_events("bad_index");
        $display("test_bad_index done");
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        send_stream(s);
        model(s, 1'b0);
        check_events("bad_checksum");
        n_checks++;
        if (bus.err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL checksum_code_hold: got %0d, expected 2", bus.err_code);
        end
        $display("test_bad_checksum done");
    endtask

    task automatic test_timeout();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h11, 8'h22};
        logic [7:0] t[$] = '{8'hA5, 8'h01, 8'h11};
        send_stream(s);
        @(negedge clk);
        check_bit("timeout_busy_before", bus.busy, 1'b1);
        repeat (TMO + 1) @(posedge clk);
        @(negedge clk);
        check_bit("timeout_busy_after", bus.busy, 1'b0);
        model(s, 1'b1);
        check_events("timeout");
        send_stream(t);
        send_byte(8'h5A, 1'b0);
        model(t, 1'b1);
        check_events("stop_bit_err");
        check_bit("stop_bit_busy", bus.busy, 1'b0);
        $display("test_timeout done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$] = '{8'hA5, 8'h01, 8'h33};
        logic [7:0] f[$] = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        send_stream(s);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        check_outputs_reset("reset_mid_outputs");
        reset = 1'b0;
        model(s, 1'b0);
        check_events("reset_mid");
        send_stream(f);
        model(f, 1'b0);
        check_events("after_reset_frame");
        $display("test_reset_mid done");
    endtask

    task automatic test_resync();
        logic [7:0] s[$] = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5};
        send_stream(s);
        model(s, 1'b0);
        check_events("resync");
        $display("test_resync done");
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] x;
        logic [7:0] b;
        for (int f = 0; f < 8; f++) begin
            s.push_back(8'hA5);
            b = 8'($urandom_range(0, 2));
            s.push_back(b);
            if (b < NI) begin
                x = 8'h00;
                for (int k = 0; k < ELEMS; k++) begin
                    b = 8'($urandom);
                    s.push_back(b);
                    x = x ^ b;
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                s.push_back(x);
            end
        end
        foreach (s[i]) begin
            send_byte(s[i], 1'b1);
            repeat ($urandom_range(0, 2 * CPB)) @(posedge clk);
        end
        model(s, 1'b1);
        check_events("random");
        $display("test_random done (%0d bytes)", s.size());
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_index();
        test_bad_checksum();
        test_timeout();
        test_reset_mid();
        test_resync();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
